// File: rtl/halt_control_unit.sv
// Halt/resume sequencer: stops fetch, drains the pipe and freezes the core, then
// re-primes the IR on resume, optionally after a timed core reset.
module halt_control_unit #(
    parameter int DRAIN_CYCLES = 2,
    parameter int RESET_HOLD   = 4
) (
    input  logic HCU_Clk,
    input  logic HCU_Reset,
    input  logic HCU_Halt_Req,
    input  logic HCU_Resume_Req,
    input  logic HCU_Resume_Reset,
    output logic HCU_Insmem_Read,
    output logic HCU_Pc_En,
    output logic HCU_Ir_En,
    output logic HCU_RegFile_We_En,
    output logic HCU_Core_Reset_n,
    output logic HCU_Halted,
    output logic HCU_Busy
);

    typedef enum logic [2:0] {
        S_RUN    = 3'b000,
        S_STOP   = 3'b001,
        S_DRAIN  = 3'b010,
        S_HALTED = 3'b011,
        S_HOLD   = 3'b100,
        S_FEED   = 3'b101
    } state_t;

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
    localparam logic [3:0] HOLD_LAST  = 4'(RESET_HOLD - 1);

    state_t     state;
    logic [3:0] cnt;
    logic [6:0] outs;

    always_ff @(posedge HCU_Clk) begin
        if (HCU_Reset) begin
            state <= S_HOLD;
            cnt   <= '0;
        end else begin
            case (state)
                S_RUN: begin
                    if (HCU_Halt_Req) begin
                        state <= S_STOP;
                        cnt   <= '0;
                    end
                end
                S_STOP: begin
                    cnt   <= '0;
                    state <= (DRAIN_CYCLES > 0) ? S_DRAIN : S_HALTED;
                end
                S_DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        state <= S_HALTED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_HALTED: begin
                    // A pending halt outranks a simultaneous resume
                    if (!HCU_Halt_Req && HCU_Resume_Req) begin
                        state <= HCU_Resume_Reset ? S_HOLD : S_FEED;
                        cnt   <= '0;
                    end
                end
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state <= S_FEED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_FEED: begin
                    state <= S_RUN;
                    cnt   <= '0;
                end
                default: begin
                    state <= S_HOLD;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // {Insmem_Read, Pc_En, Ir_En, RegFile_We_En, Core_Reset_n, Halted, Busy}
    always_comb begin
        outs = 7'b0000001;
        case (state)
            S_RUN:    outs = 7'b1111100;
            S_STOP:   outs = 7'b0011101;
            S_DRAIN:  outs = 7'b0001101;
            S_HALTED: outs = 7'b0000110;
            S_HOLD:   outs = 7'b0000001;
            S_FEED:   outs = 7'b1010101;
            default:  outs = 7'b0000001;
        endcase
    end

    assign {HCU_Insmem_Read, HCU_Pc_En, HCU_Ir_En, HCU_RegFile_We_En,
            HCU_Core_Reset_n, HCU_Halted, HCU_Busy} = outs;

endmodule

// File: tb/tb_halt_control_unit.sv
// Bench for halt_control_unit: a DRAIN_CYCLES=2 and a DRAIN_CYCLES=0 build share
// stimulus; directed vector table, hand sequences, then random vs. a phase model.
module tb_halt_control_unit;

    localparam int RH = 3;
    localparam int DA = 2;
    localparam int DB = 0;

    localparam logic [6:0] O_RUN  = 7'b1111100;
    localparam logic [6:0] O_STOP = 7'b0011101;
    localparam logic [6:0] O_DRN  = 7'b0001101;
    localparam logic [6:0] O_HLT  = 7'b0000110;
    localparam logic [6:0] O_HOLD = 7'b0000001;
    localparam logic [6:0] O_FEED = 7'b1010101;

    localparam int P_RUN = 0, P_STOP = 1, P_DRAIN = 2, P_HALTED = 3, P_HOLD = 4, P_FEED = 5;

    logic HCU_Clk = 1'b0;
    logic HCU_Reset = 1'b0, HCU_Halt_Req = 1'b0, HCU_Resume_Req = 1'b0, HCU_Resume_Reset = 1'b0;
    logic a_ins, a_pc, a_ir, a_we, a_crn, a_hlt, a_bsy;
    logic b_ins, b_pc, b_ir, b_we, b_crn, b_hlt, b_bsy;
    logic [6:0] out_a, out_b;

    int n_checks = 0;
    int n_fail   = 0;
    int ma_ph = P_RUN, ma_left = 0, mb_ph = P_RUN, mb_left = 0;

    always #5 HCU_Clk = ~HCU_Clk;

    halt_control_unit #(.DRAIN_CYCLES(DA), .RESET_HOLD(RH)) u_a (
        .HCU_Clk(HCU_Clk), .HCU_Reset(HCU_Reset), .HCU_Halt_Req(HCU_Halt_Req),
        .HCU_Resume_Req(HCU_Resume_Req), .HCU_Resume_Reset(HCU_Resume_Reset),
        .HCU_Insmem_Read(a_ins), .HCU_Pc_En(a_pc), .HCU_Ir_En(a_ir),
        .HCU_RegFile_We_En(a_we), .HCU_Core_Reset_n(a_crn), .HCU_Halted(a_hlt),
        .HCU_Busy(a_bsy));

    halt_control_unit #(.DRAIN_CYCLES(DB), .RESET_HOLD(RH)) u_b (
        .HCU_Clk(HCU_Clk), .HCU_Reset(HCU_Reset), .HCU_Halt_Req(HCU_Halt_Req),
        .HCU_Resume_Req(HCU_Resume_Req), .HCU_Resume_Reset(HCU_Resume_Reset),
        .HCU_Insmem_Read(b_ins), .HCU_Pc_En(b_pc), .HCU_Ir_En(b_ir),
        .HCU_RegFile_We_En(b_we), .HCU_Core_Reset_n(b_crn), .HCU_Halted(b_hlt),
        .HCU_Busy(b_bsy));

    assign out_a = {a_ins, a_pc, a_ir, a_we, a_crn, a_hlt, a_bsy};
    assign out_b = {b_ins, b_pc, b_ir, b_we, b_crn, b_hlt, b_bsy};

    typedef struct {
        bit         rst;
        bit         halt;
        bit         res;
        bit         rr;
        logic [6:0] exp;
        string      name;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [6:0] phase_out(input int ph);
        case (ph)
            P_RUN:    return O_RUN;
            P_STOP:   return O_STOP;
            P_DRAIN:  return O_DRN;
            P_HALTED: return O_HLT;
            P_FEED:   return O_FEED;
            default:  return O_HOLD;
        endcase
    endfunction

    // Phase model: 'left' counts down the cycles remaining in a timed phase
    task automatic model_step(inout int ph, inout int left, input int drain,
                              input bit r, input bit h, input bit q, input bit rr);
        if (r) begin
            ph = P_HOLD; left = RH;
        end else begin
            case (ph)
                P_RUN:    if (h) ph = P_STOP;
                P_STOP:   if (drain > 0) begin ph = P_DRAIN; left = drain; end
                          else ph = P_HALTED;
                P_DRAIN:  begin left--; if (left == 0) ph = P_HALTED; end
                P_HALTED: if (!h && q) begin
                              if (rr) begin ph = P_HOLD; left = RH; end
                              else ph = P_FEED;
                          end
                P_HOLD:   begin left--; if (left == 0) ph = P_FEED; end
                default:  ph = P_RUN;
            endcase
        end
    endtask

    task automatic tick(input bit r, input bit h, input bit q, input bit rr);
        HCU_Reset = r; HCU_Halt_Req = h; HCU_Resume_Req = q; HCU_Resume_Reset = rr;
        @(posedge HCU_Clk);
        model_step(ma_ph, ma_left, DA, r, h, q, rr);
        model_step(mb_ph, mb_left, DB, r, h, q, rr);
        #1;
    endtask

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input bit r, input bit h, input bit q, input bit rr,
                       input logic [6:0] e, input string n);
        tbl.push_back('{rst: r, halt: h, res: q, rr: rr, exp: e, name: n});
    endtask

    initial begin
        // Boot from a 2-cycle reset
        add(1,0,0,0, O_HOLD, "reset0");
        add(1,0,0,0, O_HOLD, "reset1");
        add(0,0,0,0, O_HOLD, "boot_hold1");
        add(0,0,0,0, O_HOLD, "boot_hold2");
        add(0,0,0,0, O_FEED, "boot_feed");
        add(0,0,0,0, O_RUN,  "boot_run");
        add(0,0,0,0, O_RUN,  "run_idle");
        // 1-cycle halt pulse
        add(0,1,0,0, O_STOP, "halt_stop");
        add(0,0,0,0, O_DRN,  "halt_drain1");
        add(0,0,0,0, O_DRN,  "halt_drain2");
        add(0,0,0,0, O_HLT,  "halted");
        add(0,0,0,0, O_HLT,  "halted_hold");
        // Plain resume
        add(0,0,1,0, O_FEED, "resume_feed");
        add(0,0,0,0, O_RUN,  "resume_run");
        // Resume ignored in STOP/DRAIN; halt beats resume in HALTED
        add(0,1,0,0, O_STOP, "halt2_stop");
        add(0,0,1,0, O_DRN,  "res_in_stop");
        add(0,0,1,0, O_DRN,  "res_in_drain");
        add(0,0,0,0, O_HLT,  "halt2_done");
        add(0,1,1,0, O_HLT,  "halt_beats_resume");
        // Resume with core reset
        add(0,0,1,1, O_HOLD, "rres_hold1");
        add(0,0,0,0, O_HOLD, "rres_hold2");
        add(0,0,0,0, O_HOLD, "rres_hold3");
        add(0,0,0,0, O_FEED, "rres_feed");
        add(0,0,0,0, O_RUN,  "rres_run");
        add(0,0,1,0, O_RUN,  "res_in_run");
        // Reset during DRAIN aborts
        add(0,1,0,0, O_STOP, "halt3_stop");
        add(0,0,0,0, O_DRN,  "halt3_drain");
        add(1,0,0,0, O_HOLD, "abort_hold");
        add(0,0,0,0, O_HOLD, "abort_hold2");
        add(0,0,0,0, O_HOLD, "abort_hold3");
        add(0,0,0,0, O_FEED, "abort_feed");
        add(0,0,0,0, O_RUN,  "abort_run");
        // Halt held high re-halts after resume
        add(0,1,0,0, O_STOP, "lvl_stop");
        add(0,1,0,0, O_DRN,  "lvl_drain1");
        add(0,1,0,0, O_DRN,  "lvl_drain2");
        add(0,1,0,0, O_HLT,  "lvl_halted");
        add(0,0,1,0, O_FEED, "lvl_feed");
        add(0,1,0,0, O_RUN,  "lvl_run_ignored");
        add(0,1,0,0, O_STOP, "lvl_rehalt");

        foreach (tbl[i]) begin
            tick(tbl[i].rst, tbl[i].halt, tbl[i].res, tbl[i].rr);
            check(tbl[i].name, out_a, tbl[i].exp);
        end

        // DRAIN_CYCLES=0 build: STOP goes straight to HALTED
        tick(1,0,0,0);
        check("b_reset", out_b, O_HOLD);
        for (int i = 0; i < RH; i++) tick(0,0,0,0);
        check("b_boot_feed", out_b, O_FEED);
        tick(0,0,0,0);
        check("b_boot_run", out_b, O_RUN);
        tick(0,1,0,0);
        check("b_stop", out_b, O_STOP);
        check("a_stop_same_edge", out_a, O_STOP);
        tick(0,0,0,0);
        check("b_halted_h2", out_b, O_HLT);
        check("a_drain_h2", out_a, O_DRN);
        tick(0,0,0,0);
        check("b_halted_stays", out_b, O_HLT);

        // Random traffic against the phase model
        for (int n = 0; n < 3000; n++) begin
            tick(($urandom_range(63) == 0), ($urandom_range(3) == 0),
                 ($urandom_range(2) == 0), $urandom_range(1) == 1);
            check("rand_a", out_a, phase_out(ma_ph));
            check("rand_b", out_b, phase_out(mb_ph));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
